// File: rtl/memory_stage_wait.sv
// MIPS MEM stage: sized loads/stores on an internal word array with WAIT_STATES wait cycles.
// Define MEM_STAGE_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of truncating the address.
module memory_stage_wait #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 10,
    parameter int NB_REG      = 5,
    parameter int WAIT_STATES = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_exec_mode,
    input  logic               i_step,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_write_data,
    input  logic [NB_REG-1:0]  i_rt_rd,
    input  logic               i_reg_write,
    input  logic               i_mem_to_reg,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic               o_stall,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_REG-1:0]  o_rt_rd,
    output logic               o_reg_write,
    output logic               o_mem_to_reg,
    output logic               o_halt,
    output logic               o_misalign,
    output logic [NB_DATA-1:0] o_dbg_data
);

    localparam int         DEPTH    = 2**NB_ADDR;
    localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state;
    logic [2:0]         cnt;
    logic [NB_DATA-1:0] mem [DEPTH];

    logic               rd_p0, wr_p0, uns_p0, reg_write_p0, mem_to_reg_p0;
    logic [1:0]         size_p0;
    logic [NB_DATA-1:0] addr_p0, wdata_p0;
    logic [NB_REG-1:0]  rt_rd_p0;

    logic               enable, accept, in_mem, in_idle, complete, misalign;
    logic               cur_rd, cur_wr, cur_uns, cur_rw, cur_m2r;
    logic [1:0]         cur_size, lane;
    logic [NB_DATA-1:0] cur_addr, cur_wdata, rd_word;
    logic [NB_REG-1:0]  cur_rt_rd;
    logic [NB_ADDR-1:0] word_idx;

    function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'b00:   lane_of = addr;
            2'b01:   lane_of = {addr[1], 1'b0};
            default: lane_of = 2'b00;
        endcase
    endfunction

    function automatic logic [NB_DATA-1:0] load_extend(input logic [NB_DATA-1:0] word,
                                                       input logic [1:0] size,
                                                       input logic [1:0] ln,
                                                       input logic uns);
        logic [NB_DATA-1:0] sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> {ln, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            2'b00:   load_extend = uns ? NB_DATA'($unsigned(b)) : NB_DATA'(b);
            2'b01:   load_extend = uns ? NB_DATA'($unsigned(h)) : NB_DATA'(h);
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic [NB_DATA-1:0] store_merge(input logic [NB_DATA-1:0] old,
                                                       input logic [NB_DATA-1:0] data,
                                                       input logic [1:0] size,
                                                       input logic [1:0] ln);
        logic [NB_DATA-1:0] mask;
        case (size)
            2'b00:   mask = NB_DATA'(8'hFF) << {ln, 3'b000};
            2'b01:   mask = NB_DATA'(16'hFFFF) << {ln, 3'b000};
            default: mask = '1;
        endcase
        store_merge = (old & ~mask) | ((data << {ln, 3'b000}) & mask);
    endfunction

    // Stage 0: acceptance and the operand set seen by the completing access
    assign enable  = ~i_exec_mode | i_step;
    assign in_idle = (state == IDLE);
    assign accept  = in_idle & i_valid & enable & ~o_halt;
    assign in_mem  = i_mem_read | i_mem_write;

    assign cur_rd    = in_idle ? i_mem_read   : rd_p0;
    assign cur_wr    = in_idle ? i_mem_write  : wr_p0;
    assign cur_size  = in_idle ? i_size       : size_p0;
    assign cur_uns   = in_idle ? i_unsigned   : uns_p0;
    assign cur_addr  = in_idle ? i_alu_result : addr_p0;
    assign cur_wdata = in_idle ? i_write_data : wdata_p0;
    assign cur_rt_rd = in_idle ? i_rt_rd      : rt_rd_p0;
    assign cur_rw    = in_idle ? i_reg_write  : reg_write_p0;
    assign cur_m2r   = in_idle ? i_mem_to_reg : mem_to_reg_p0;

    assign complete = (accept & (~in_mem | (WAIT_STATES == 0))) |
                      ((state == ACCESS) & (cnt == 3'd1));

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misalign = (cur_rd | cur_wr) &
                      (((cur_size == 2'b01) & cur_addr[0]) |
                       (cur_size[1] & (cur_addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign lane     = lane_of(cur_size, cur_addr[1:0]);
    assign word_idx = cur_addr[NB_ADDR+1:2];
    assign rd_word  = mem[word_idx];

    always_ff @(posedge i_clock) begin
        if (accept) begin
            rd_p0         <= i_mem_read;
            wr_p0         <= i_mem_write;
            size_p0       <= i_size;
            uns_p0        <= i_unsigned;
            addr_p0       <= i_alu_result;
            wdata_p0      <= i_write_data;
            rt_rd_p0      <= i_rt_rd;
            reg_write_p0  <= i_reg_write;
            mem_to_reg_p0 <= i_mem_to_reg;
        end
    end

    // Stage 1: memory update at the completion edge; an in-flight access is dropped under reset
    always_ff @(posedge i_clock) begin
        if (complete && cur_wr && !misalign && i_reset)
            mem[word_idx] <= store_merge(rd_word, cur_wdata, cur_size, lane);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            o_stall      <= 1'b0;
            o_valid      <= 1'b0;
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_rt_rd      <= '0;
            o_reg_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_halt       <= 1'b0;
            o_misalign   <= 1'b0;
            o_dbg_data   <= '0;
        end else begin
            o_valid    <= 1'b0;
            o_dbg_data <= mem[i_dbg_addr];
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (i_halt)
                            o_halt <= 1'b1;
                        if (in_mem && (WAIT_STATES != 0)) begin
                            state   <= ACCESS;
                            cnt     <= WAIT_CNT;
                            o_stall <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state   <= IDLE;
                        o_stall <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (complete) begin
                o_valid      <= 1'b1;
                o_read_data  <= (cur_rd && !cur_wr && !misalign) ?
                                load_extend(rd_word, cur_size, lane, cur_uns) : '0;
                o_alu_result <= cur_addr;
                o_rt_rd      <= cur_rt_rd;
                o_reg_write  <= cur_rw & ~misalign;
                o_mem_to_reg <= cur_m2r;
                o_misalign   <= misalign;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage_wait.sv
// Directed bench for memory_stage_wait: scoreboard of expected MEM/WB results checked on o_valid.
module tb_memory_stage_wait;

    localparam int W = 2;

    logic        i_clock = 1'b0;
    logic        i_reset, i_valid, i_exec_mode, i_step, i_mem_read, i_mem_write;
    logic [1:0]  i_size;
    logic        i_unsigned, i_reg_write, i_mem_to_reg, i_halt;
    logic [31:0] i_alu_result, i_write_data;
    logic [4:0]  i_rt_rd;
    logic [9:0]  i_dbg_addr;
    logic        o_stall, o_valid, o_reg_write, o_mem_to_reg, o_halt, o_misalign;
    logic [31:0] o_read_data, o_alu_result, o_dbg_data;
    logic [4:0]  o_rt_rd;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rt;
        logic        rw;
        logic        mis;
        logic        m2r;
    } exp_t;

    exp_t  sb[$];
    string tags[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    valid_seen = 0;
    logic [4:0] rd_idx = 5'd1;

    memory_stage_wait #(.NB_DATA(32), .NB_ADDR(10), .NB_REG(5), .WAIT_STATES(W)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_exec_mode(i_exec_mode),
        .i_step(i_step), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_alu_result(i_alu_result), .i_write_data(i_write_data),
        .i_rt_rd(i_rt_rd), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
        .i_halt(i_halt), .i_dbg_addr(i_dbg_addr), .o_stall(o_stall), .o_valid(o_valid),
        .o_read_data(o_read_data), .o_alu_result(o_alu_result), .o_rt_rd(o_rt_rd),
        .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg), .o_halt(o_halt),
        .o_misalign(o_misalign), .o_dbg_data(o_dbg_data)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every o_valid pulse must match the oldest pending expectation
    always @(negedge i_clock) begin
        if (i_reset === 1'b1 && o_valid === 1'b1) begin
            valid_seen++;
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_valid: observed o_valid=1 expected no output, alu=%h", o_alu_result);
            end
            if (sb.size() != 0) begin
                exp_t  e;
                string t;
                e = sb.pop_front();
                t = tags.pop_front();
                chk({t, "_rdata"}, o_read_data, e.rdata);
                chk({t, "_alu"},   o_alu_result, e.alu);
                chk({t, "_rt"},    32'(o_rt_rd), 32'(e.rt));
                chk({t, "_rw"},    32'(o_reg_write), 32'(e.rw));
                chk({t, "_mis"},   32'(o_misalign), 32'(e.mis));
                chk({t, "_m2r"},   32'(o_mem_to_reg), 32'(e.m2r));
                chk({t, "_nostall"}, 32'(o_stall), 32'd0);
            end
        end
    end

    task automatic op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic halt, input logic [31:0] exp_rdata, input logic exp_mis);
        exp_t e;
        int   k;
        int   stalls;
        int   exp_lat;
        @(negedge i_clock);
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_size = sz; i_unsigned = uns;
        i_alu_result = addr; i_write_data = wdata; i_rt_rd = rd_idx;
        i_reg_write = ~wr; i_mem_to_reg = rd; i_halt = halt;
        e.rdata = exp_rdata; e.alu = addr; e.rt = rd_idx;
        e.rw = ~wr & ~exp_mis; e.mis = exp_mis; e.m2r = rd;
        sb.push_back(e);
        tags.push_back(tag);
        rd_idx = rd_idx + 5'd1;
        @(posedge i_clock); #1;
        i_valid = 1'b0; i_halt = 1'b0;
        k = 0; stalls = 0;
        while (o_valid !== 1'b1 && k < 20) begin
            if (o_stall === 1'b1) stalls++;
            @(posedge i_clock); #1;
            k++;
        end
        exp_lat = (rd | wr) ? W : 0;
        chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
        chk({tag, "_stalls"},  32'(stalls), 32'(exp_lat));
        @(posedge i_clock); #1;
    endtask

    initial begin
        int base;
        i_reset = 1'b0; i_valid = 1'b0; i_exec_mode = 1'b0; i_step = 1'b0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
        i_alu_result = '0; i_write_data = '0; i_rt_rd = '0; i_reg_write = 1'b0;
        i_mem_to_reg = 1'b0; i_halt = 1'b0; i_dbg_addr = 10'd4;
        repeat (3) @(posedge i_clock);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_halt",  32'(o_halt), 32'd0);
        chk("rst_rdata", o_read_data, 32'd0);
        chk("rst_alu",   o_alu_result, 32'd0);
        chk("rst_dbg",   o_dbg_data, 32'd0);
        chk("rst_mis",   32'(o_misalign), 32'd0);
        @(negedge i_clock);
        i_reset = 1'b1;

        op("sw_beef", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
        @(posedge i_clock); #1;
        chk("dbg_word4", o_dbg_data, 32'hDEADBEEF);

        op("lb_13",  1, 0, 2'b00, 0, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 0);
        op("lbu_13", 1, 0, 2'b00, 1, 32'h13, 32'h0, 0, 32'h000000DE, 0);
        op("lh_10",  1, 0, 2'b01, 0, 32'h10, 32'h0, 0, 32'hFFFFBEEF, 0);
        op("lhu_12", 1, 0, 2'b01, 1, 32'h12, 32'h0, 0, 32'h0000DEAD, 0);
        op("sb_11",  0, 1, 2'b00, 0, 32'h11, 32'hAAAAAA55, 0, 32'h0, 0);
        op("lw_10",  1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        op("lw_12",  1, 0, 2'b10, 0, 32'h12, 32'h0, 0, 32'h0, 1);
        op("sh_13",  0, 1, 2'b01, 0, 32'h13, 32'h00001234, 0, 32'h0, 1);
        op("lw_10b", 1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEAD55EF, 0);
`else
        op("lw_12",  1, 0, 2'b10, 0, 32'h12, 32'h0, 0, 32'hDEAD55EF, 0);
        op("sh_13",  0, 1, 2'b01, 0, 32'h13, 32'h00001234, 0, 32'h0, 0);
        op("lw_10b", 1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h123455EF, 0);
`endif
        op("alu",     0, 0, 2'b10, 0, 32'hCAFE0001, 32'h0, 0, 32'h0, 0);
        op("sw_wrap", 0, 1, 2'b10, 0, 32'h1020, 32'h0BADF00D, 0, 32'h0, 0);
        op("lw_20",   1, 0, 2'b11, 0, 32'h20, 32'h0, 0, 32'h0BADF00D, 0);

        // Single-step: no acceptance without a step pulse, exactly one with it
        @(negedge i_clock);
        i_exec_mode = 1'b1; i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_alu_result = 32'h5A5A0000; i_rt_rd = 5'd9; i_reg_write = 1'b1; i_mem_to_reg = 1'b0;
        base = valid_seen;
        repeat (4) @(negedge i_clock);
        #1;
        chk("step_none", 32'(valid_seen), 32'(base));
        sb.push_back('{rdata: 32'h0, alu: 32'h5A5A0000, rt: 5'd9, rw: 1'b1, mis: 1'b0, m2r: 1'b0});
        tags.push_back("step");
        @(negedge i_clock);
        i_step = 1'b1;
        @(negedge i_clock);
        i_step = 1'b0;
        repeat (3) @(negedge i_clock);
        #1;
        chk("step_one", 32'(valid_seen), 32'(base + 1));
        i_valid = 1'b0; i_exec_mode = 1'b0;

        op("sw_40", 0, 1, 2'b10, 0, 32'h40, 32'h11111111, 0, 32'h0, 0);

        // Reset during the wait of a store: no write, outputs cleared
        @(negedge i_clock);
        i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b1; i_size = 2'b10;
        i_alu_result = 32'h40; i_write_data = 32'h22222222;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        chk("abort_stall_on", 32'(o_stall), 32'd1);
        i_reset = 1'b0;
        #1;
        chk("abort_stall", 32'(o_stall), 32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_alu",   o_alu_result, 32'd0);
        chk("abort_rt",    32'(o_rt_rd), 32'd0);
        chk("abort_dbg",   o_dbg_data, 32'd0);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1; i_mem_write = 1'b0; i_dbg_addr = 10'd16;
        repeat (2) @(posedge i_clock);
        #1;
        chk("abort_word16", o_dbg_data, 32'h11111111);

        op("halt", 0, 0, 2'b10, 0, 32'h77, 32'h0, 1, 32'h0, 0);
        chk("halt_set", 32'(o_halt), 32'd1);
        @(negedge i_clock);
        i_valid = 1'b1; i_mem_write = 1'b1; i_size = 2'b10;
        i_alu_result = 32'h40; i_write_data = 32'h99999999;
        base = valid_seen;
        repeat (6) @(negedge i_clock);
        #1;
        chk("halt_ignore", 32'(valid_seen), 32'(base));
        chk("halt_nostall", 32'(o_stall), 32'd0);
        chk("halt_sticky", 32'(o_halt), 32'd1);
        i_valid = 1'b0; i_mem_write = 1'b0;
        @(posedge i_clock); #1;
        chk("halt_word16", o_dbg_data, 32'h11111111);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected $finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
